alu_mc: RTL and testbench

- Parametrised multi-cycle ALU for the simplified RISC-V datapath.
- Extends the single-cycle op set with XOR, shifts, signed/unsigned compare, an iterative multiply and an iterative unsigned divide/remainder.
- Operands enter through a valid/ready request port. Results leave through a valid/ready response port. Results are registered.
- Sits between the operand-fetch stage and writeback. Stalls the pipeline while an iterative op runs.

---
 rtl/alu_mc.sv | 187 ++++++++++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative shift-add
// multiply and restoring unsigned divide/remainder behind valid/ready handshakes.
module alu_mc #(
    parameter int SWIDTH = 4,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] src1,
    input  logic [DWIDTH-1:0] src2,
    input  logic [SWIDTH-1:0] sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] res,
    output logic              res_is_0,
    output logic              busy
);
    localparam int SHW = $clog2(DWIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SWIDTH-1:0] OP_AND  = SWIDTH'(0);
    localparam logic [SWIDTH-1:0] OP_OR   = SWIDTH'(1);
    localparam logic [SWIDTH-1:0] OP_ADD  = SWIDTH'(2);
    localparam logic [SWIDTH-1:0] OP_XOR  = SWIDTH'(3);
    localparam logic [SWIDTH-1:0] OP_SLL  = SWIDTH'(4);
    localparam logic [SWIDTH-1:0] OP_SRL  = SWIDTH'(5);
    localparam logic [SWIDTH-1:0] OP_SUB  = SWIDTH'(6);
    localparam logic [SWIDTH-1:0] OP_SLT  = SWIDTH'(7);
    localparam logic [SWIDTH-1:0] OP_SRA  = SWIDTH'(8);
    localparam logic [SWIDTH-1:0] OP_SLTU = SWIDTH'(9);
    localparam logic [SWIDTH-1:0] OP_MUL  = SWIDTH'(10);
    localparam logic [SWIDTH-1:0] OP_DIVU = SWIDTH'(11);
    localparam logic [SWIDTH-1:0] OP_REMU = SWIDTH'(12);

    logic [1:0]        state;
    logic [DWIDTH-1:0] res_q;
    logic [DWIDTH-1:0] a_q;
    logic [DWIDTH-1:0] b_q;
    logic [DWIDTH-1:0] acc_q;
    logic [SHW:0]      cnt_q;
    logic              mul_q;
    logic              rem_q;

    logic [SHW-1:0]    shamt;
    logic [DWIDTH-1:0] single_res;
    logic              is_iter;
    logic [DWIDTH:0]   trial;
    logic              ge;
    logic [DWIDTH-1:0] acc_n;
    logic [DWIDTH-1:0] a_n;
    logic [DWIDTH-1:0] b_n;
    logic [DWIDTH-1:0] iter_res;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);
    assign res       = res_q;
    assign res_is_0  = (res_q == '0);

    assign shamt   = src2[SHW-1:0];
    assign is_iter = (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);

    always_comb begin
        single_res = '0;
        case (sel)
            OP_AND:  single_res = src1 & src2;
            OP_OR:   single_res = src1 | src2;
            OP_ADD:  single_res = src1 + src2;
            OP_XOR:  single_res = src1 ^ src2;
            OP_SLL:  single_res = src1 << shamt;
            OP_SRL:  single_res = src1 >> shamt;
            OP_SUB:  single_res = src1 + ~src2 + DWIDTH'(1);
            OP_SLT:  single_res = DWIDTH'($signed(src1) < $signed(src2));
            OP_SRA:  single_res = $signed(src1) >>> shamt;
            OP_SLTU: single_res = DWIDTH'(src1 < src2);
            default: single_res = '0;
        endcase
    end

    // Divide reuses a_q as the dividend/quotient shift register: each step shifts one
    // dividend bit into the partial remainder and one quotient bit into a_q's LSB.
    assign trial = {acc_q, a_q[DWIDTH-1]};
    assign ge    = (trial >= {1'b0, b_q});

    always_comb begin
        acc_n = acc_q;
        a_n   = a_q;
        b_n   = b_q;
        if (mul_q) begin
            acc_n = acc_q + (b_q[0] ? a_q : '0);
            a_n   = a_q << 1;
            b_n   = b_q >> 1;
        end else begin
            acc_n = ge ? DWIDTH'(trial - {1'b0, b_q}) : trial[DWIDTH-1:0];
            a_n   = {a_q[DWIDTH-2:0], ge};
        end
    end

    assign iter_res = (mul_q || rem_q) ? acc_n : a_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            res_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            mul_q <= 1'b0;
            rem_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_iter) begin
                            a_q   <= src1;
                            b_q   <= src2;
                            acc_q <= '0;
                            cnt_q <= (SHW+1)'(DWIDTH);
                            mul_q <= (sel == OP_MUL);
                            rem_q <= (sel == OP_REMU);
                            state <= S_BUSY;
                        end else begin
                            res_q <= single_res;
                            state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    a_q   <= a_n;
                    b_q   <= b_n;
                    acc_q <= acc_n;
                    cnt_q <= cnt_q - (SHW+1)'(1);
                    if (cnt_q == (SHW+1)'(1)) begin
                        res_q <= iter_res;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

`ifdef SVA_ON
// Handshake protocol checker, attached to every alu_mc instance.
module alu_mc_sva #(
    parameter int DWIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    input logic              in_ready,
    input logic              out_valid,
    input logic              out_ready,
    input logic              busy,
    input logic [DWIDTH-1:0] res
);
    a_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid);
    a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> $stable(res));
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
    a_busy_stall: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> !in_ready);
endmodule

bind alu_mc alu_mc_sva #(.DWIDTH(DWIDTH)) u_alu_mc_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .res       (res)
);
`endif

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (DWIDTH=8): reference-model scoreboard, latency,
// reset abort, divide-by-zero and backpressure scenarios.
module tb_alu_mc;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] src1 = '0;
    logic [DW-1:0] src2 = '0;
    logic [3:0]    sel = '0;
    logic          in_ready;
    logic          out_valid;
    logic          res_is_0;
    logic          busy;
    logic [DW-1:0] res;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mc #(.SWIDTH(4), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_is_0  (res_is_0),
        .busy      (busy)
    );

    function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic signed [DW-1:0] sa;
        sa = a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[2:0];
            4'd5:    return a >> b[2:0];
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            4'd8:    return sa >>> b[2:0];
            4'd9:    return (a < b) ? 8'd1 : 8'd0;
            4'd10:   return a * b;
            4'd11:   return (b == 0) ? 8'hFF : a / b;
            4'd12:   return (b == 0) ? a : a % b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_result(input string tag);
        logic [DW-1:0] e;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sb"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_res"}, res, e);
            chk({tag, "_z"}, res_is_0, (e == '0));
        end
        tick();
        chk({tag, "_idle"}, in_ready, 1);
        chk({tag, "_ovclr"}, out_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int lat);
        int cyc;
        src1 = a;
        src2 = b;
        sel = op;
        in_valid = 1'b1;
        exp_q.push_back(model(op, a, b));
        tick();
        in_valid = 1'b0;
        src1 = 8'h5A;
        src2 = 8'h03;
        sel = 4'd2;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_stall"}, in_ready, 0);
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        take_result(tag);
    endtask

    initial begin
        logic          seen;
        int            cyc;
        logic [DW-1:0] e;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_ir", in_ready, 1);
        chk("rst_res", res, 0);
        chk("rst_z", res_is_0, 1);
        chk("rst_busy", busy, 0);

        // Abort a MUL mid-flight with a two-cycle reset
        src1 = 8'h13;
        src2 = 8'h0D;
        sel = 4'd10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_ov", out_valid, 0);
        chk("abort_ir", in_ready, 1);
        chk("abort_res", res, 0);
        chk("abort_z", res_is_0, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("abort_never", seen, 0);

        out_ready = 1'b1;
        run_op("add",   4'd2,  8'hF0, 8'h20, 1);
        run_op("sub",   4'd6,  8'h05, 8'h07, 1);
        run_op("slt",   4'd7,  8'h80, 8'h01, 1);
        run_op("sltu",  4'd9,  8'h80, 8'h01, 1);
        run_op("sra",   4'd8,  8'h80, 8'h0B, 1);
        run_op("xor",   4'd3,  8'hAA, 8'hAA, 1);
        run_op("and",   4'd0,  8'hC3, 8'h5F, 1);
        run_op("or",    4'd1,  8'h81, 8'h14, 1);
        run_op("sll",   4'd4,  8'h0B, 8'hF5, 1);
        run_op("srl",   4'd5,  8'hB4, 8'h02, 1);
        run_op("mul",   4'd10, 8'h13, 8'h0D, 9);
        run_op("mulw",  4'd10, 8'hFF, 8'hFF, 9);
        run_op("divu",  4'd11, 8'd200, 8'd7, 9);
        run_op("remu",  4'd12, 8'd200, 8'd7, 9);
        run_op("div0",  4'd11, 8'h37, 8'h00, 9);
        run_op("rem0",  4'd12, 8'h37, 8'h00, 9);
        run_op("divbig",4'd11, 8'hFE, 8'hFF, 9);
        run_op("undef", 4'd15, 8'h12, 8'h34, 1);

        // Backpressure: MUL result held while a pending ADD waits
        out_ready = 1'b0;
        src1 = 8'h13;
        src2 = 8'h0D;
        sel = 4'd10;
        in_valid = 1'b1;
        exp_q.push_back(model(4'd10, 8'h13, 8'h0D));
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp_lat", cyc, 9);
        chk("bp_sb", exp_q.size(), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        src1 = 8'h0F;
        src2 = 8'h01;
        sel = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", out_valid, 1);
            chk("bp_res", res, e);
            chk("bp_z", res_is_0, (e == '0));
            chk("bp_noacc", in_ready, 0);
            tick();
        end
        chk("bp_hold", res, e);
        out_ready = 1'b1;
        tick();
        chk("bp_hand_ov", out_valid, 0);
        chk("bp_hand_ir", in_ready, 1);
        chk("bp_keep", res, e);
        exp_q.push_back(model(4'd2, 8'h0F, 8'h01));
        tick();
        in_valid = 1'b0;
        take_result("bp_add");

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
